fetch: RTL

Instruction-fetch stage feeding the decoder: on an `enabled` pulse it samples the PC, issues one word read on the instruction-memory port and registers the returned raw instruction. It then raises `completed` using the same start/complete handshake the decoder uses. It absorbs variable memory latency, aborts on `flush`, and reports misalignment, bus errors and timeouts as a fault.

---
 rtl/fetch.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fetch.sv
// Instruction-fetch stage: one word read per start pulse, registered result, fault on misalignment, bus error or timeout.
// Define FETCH_BUF_EN to add a one-entry last-fetch buffer that serves repeat fetches without a memory access.
module fetch #(
   parameter logic [31:0] RESET_INSTR = 32'h0000_0013,
   parameter int unsigned MAX_WAIT    = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enabled,
   input  logic [31:0] pc,
   input  logic        flush,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   input  logic        mem_err,
   output logic        completed,
   output logic [31:0] instr_raw,
   output logic [31:0] pc_out,
   output logic        fault
);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, DONE} state_t;

   localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

   state_t      state;
   logic [7:0]  wait_cnt;
   logic        timed_out;
   logic        done_q;
   logic        hit;
   logic [31:0] buf_word;

`ifdef FETCH_BUF_EN
   logic [29:0] buf_tag;
   logic [31:0] buf_data;
   logic        buf_vld;
   logic        fill;

   assign fill     = (state == WAIT) && mem_rvalid && !mem_err && !flush;
   assign hit      = buf_vld && (buf_tag == pc[31:2]);
   assign buf_word = buf_data;

   // Tag and data carry no reset; the valid bit alone qualifies them.
   always_ff @(posedge clk) begin
      if (fill) begin
         buf_tag  <= mem_addr[31:2];
         buf_data <= mem_rdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        buf_vld <= 1'b0;
      else if (flush) buf_vld <= 1'b0;
      else if (fill)  buf_vld <= 1'b1;
   end
`else
   assign hit      = 1'b0;
   assign buf_word = RESET_INSTR;
`endif

   // A new start cycle must never see the previous result as still valid.
   assign completed = done_q & ~enabled;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         done_q    <= 1'b0;
         mem_req   <= 1'b0;
         mem_addr  <= '0;
         pc_out    <= '0;
         fault     <= 1'b0;
         instr_raw <= RESET_INSTR;
         wait_cnt  <= '0;
         timed_out <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (flush) begin
                  state  <= IDLE;
                  done_q <= 1'b0;
               end else if (enabled) begin
                  done_q <= 1'b0;
                  pc_out <= pc;
                  fault  <= 1'b0;
                  if (pc[1:0] != 2'b00) begin
                     state     <= DONE;
                     done_q    <= 1'b1;
                     fault     <= 1'b1;
                     instr_raw <= RESET_INSTR;
                  end else if (hit) begin
                     state     <= DONE;
                     done_q    <= 1'b1;
                     instr_raw <= buf_word;
                  end else begin
                     state    <= REQ;
                     mem_req  <= 1'b1;
                     mem_addr <= pc;
                  end
               end
            end
            REQ: begin
               if (mem_gnt) begin
                  mem_req   <= 1'b0;
                  wait_cnt  <= '0;
                  timed_out <= 1'b0;
                  state     <= flush ? DRAIN : WAIT;
               end else if (flush) begin
                  mem_req <= 1'b0;
                  state   <= IDLE;
               end
            end
            WAIT: begin
               wait_cnt <= wait_cnt + 8'd1;
               // A flush racing the response has nothing left to drain.
               if (flush) begin
                  state <= mem_rvalid ? IDLE : DRAIN;
               end else if (mem_rvalid) begin
                  state     <= DONE;
                  done_q    <= 1'b1;
                  fault     <= mem_err;
                  instr_raw <= mem_err ? RESET_INSTR : mem_rdata;
               end else if (wait_cnt + 8'd1 == WAIT_LIMIT) begin
                  state     <= DRAIN;
                  fault     <= 1'b1;
                  instr_raw <= RESET_INSTR;
                  timed_out <= 1'b1;
               end
            end
            DRAIN: begin
               if (mem_rvalid) begin
                  state     <= (timed_out && !flush) ? DONE : IDLE;
                  done_q    <= timed_out && !flush;
                  timed_out <= 1'b0;
               end else if (flush) begin
                  timed_out <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
